// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter that accepts one binary word at a time from NREQ requesters,
// converts it to Gray code and holds it on a valid/ready output port.
module gray_conv_arbiter #(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   output logic [IDW-1:0]        out_id,
   input  logic                  out_ready,
   output logic                  busy,
   output logic [7:0]            conv_cnt
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CONVERT = 2'd1;
   localparam logic [1:0] HOLD    = 2'd2;

   logic [1:0]       state_q,     state_d;
   logic [IDW-1:0]   rrPtr_q,     rrPtr_d;
   logic [IDW-1:0]   latchIdx_q,  latchIdx_d;
   logic [WIDTH-1:0] latchData_q, latchData_d;
   logic             outValid_q,  outValid_d;
   logic [WIDTH-1:0] outData_q,   outData_d;
   logic [IDW-1:0]   outId_q,     outId_d;
   logic [7:0]       convCnt_q,   convCnt_d;

   logic             grantFound;
   logic [IDW-1:0]   grantIdx;
   logic [IDW-1:0]   scanIdx;
   logic [WIDTH-1:0] grantData;

   // Scan upward from the round-robin pointer; IDW-bit addition wraps modulo NREQ.
   always_comb begin
      grantFound = 1'b0;
      grantIdx   = rrPtr_q;
      scanIdx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         scanIdx = rrPtr_q + IDW'(k);
         if (!grantFound && req_valid[scanIdx]) begin
            grantFound = 1'b1;
            grantIdx   = scanIdx;
         end
      end
   end

   assign grantData = req_data[int'(grantIdx)*WIDTH +: WIDTH];

   always_comb begin
      req_ready = '0;
      if (rst_n && (state_q == IDLE) && grantFound) begin
         req_ready[grantIdx] = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      rrPtr_d     = rrPtr_q;
      latchIdx_d  = latchIdx_q;
      latchData_d = latchData_q;
      outValid_d  = outValid_q;
      outData_d   = outData_q;
      outId_d     = outId_q;
      convCnt_d   = convCnt_q;
      case (state_q)
         IDLE: begin
            if (grantFound) begin
               latchIdx_d  = grantIdx;
               latchData_d = grantData;
               state_d     = CONVERT;
            end
         end
         CONVERT: begin
            outData_d  = latchData_q ^ (latchData_q >> 1);
            outId_d    = latchIdx_q;
            outValid_d = 1'b1;
            state_d    = HOLD;
         end
         HOLD: begin
            // Pointer moves past the owner only once the consumer has taken the word.
            if (out_ready) begin
               outValid_d = 1'b0;
               rrPtr_d    = latchIdx_q + IDW'(1);
               convCnt_d  = convCnt_q + 8'd1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rrPtr_q     <= '0;
         latchIdx_q  <= '0;
         latchData_q <= '0;
         outValid_q  <= 1'b0;
         outData_q   <= '0;
         outId_q     <= '0;
         convCnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         rrPtr_q     <= rrPtr_d;
         latchIdx_q  <= latchIdx_d;
         latchData_q <= latchData_d;
         outValid_q  <= outValid_d;
         outData_q   <= outData_d;
         outId_q     <= outId_d;
         convCnt_q   <= convCnt_d;
      end
   end

   assign out_valid = outValid_q;
   assign out_data  = outData_q;
   assign out_id    = outId_q;
   assign conv_cnt  = convCnt_q;
   assign busy      = (state_q != IDLE);

endmodule
